// File: rtl/evaluate_poly_gf32.sv
// evaluate_poly_gf32
// Evaluates a GF256-coefficient polynomial at T points of GF(2^32) with
// Horner's rule. The coefficients are read from an external memory with one
// cycle of read latency. The multiplications are handed to an external
// GF(2^32) multiplier through a start/done handshake.
// Optional feature macro: EVALUATE_FIRST_MUL_SKIP_EN. When it is defined, the
// leading coefficient is loaded straight into the accumulator, so its
// multiplication by zero is skipped. The results are the same in both builds.
module evaluate_poly_gf32 #(
  parameter int T      = 3,
  parameter int N_COEF = 230,
  localparam int AW    = (N_COEF > 1) ? $clog2(N_COEF) : 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [32*T-1:0] i_r_eps,
  output logic [AW-1:0]   o_q_s_addr,
  output logic            o_q_s_rd,
  input  logic [7:0]      i_q_s,
  output logic            o_start_mul32,
  output logic [31:0]     o_x_mul32,
  output logic [31:0]     o_y_mul32,
  input  logic [31:0]     i_o_mul32,
  input  logic            i_done_mul32,
  output logic [32*T-1:0] o_evaluate_out,
  output logic            o_busy,
  output logic            o_done
);

  localparam int JW = (T > 1) ? $clog2(T) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(N_COEF - 1);
  localparam logic [JW-1:0] LAST_J   = JW'(T - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD        = 3'd1,
    RD_WAIT   = 3'd2,
    MUL_START = 3'd3,
    MUL_WAIT  = 3'd4,
    NEXT      = 3'd5,
    DONE      = 3'd6
  } state_t;

  state_t            state_reg, state_next;
  logic [31:0]       acc_reg;
  logic [7:0]        coef_reg;
  logic [AW-1:0]     idx_reg;
  logic [JW-1:0]     j_reg;
  logic [32*T-1:0]   r_eps_reg;
  logic [32*T-1:0]   eval_out_reg;
  logic              last_idx;
  logic              last_point;

  assign last_idx   = (idx_reg == LAST_IDX);
  assign last_point = (j_reg == LAST_J);

  // State register; reset wins over everything, including a start
  always_ff @(posedge i_clk) begin
    if (i_rst) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic: read, multiply-accumulate, then step coefficient or point
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (i_start) state_next = RD;
      RD:        state_next = RD_WAIT;
`ifdef EVALUATE_FIRST_MUL_SKIP_EN
      RD_WAIT:   state_next = last_idx ? NEXT : MUL_START;
`else
      RD_WAIT:   state_next = MUL_START;
`endif
      MUL_START: state_next = MUL_WAIT;
      MUL_WAIT:  if (i_done_mul32) state_next = NEXT;
      NEXT: begin
        if (idx_reg != '0)   state_next = RD;
        else if (!last_point) state_next = RD;
        else                  state_next = DONE;
      end
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Output decode: single-cycle strobes derived purely from the current state
  always_comb begin
    o_q_s_rd      = 1'b0;
    o_start_mul32 = 1'b0;
    o_done        = 1'b0;
    o_busy        = 1'b0;
    case (state_reg)
      RD:        begin o_q_s_rd = 1'b1;      o_busy = 1'b1; end
      RD_WAIT:   o_busy = 1'b1;
      MUL_START: begin o_start_mul32 = 1'b1; o_busy = 1'b1; end
      MUL_WAIT:  o_busy = 1'b1;
      NEXT:      o_busy = 1'b1;
      DONE:      o_done = 1'b1;
      default:   ;
    endcase
  end

  // Datapath: latch points, accumulate Horner terms, store per-point results
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_reg      <= '0;
      coef_reg     <= '0;
      idx_reg      <= '0;
      j_reg        <= '0;
      r_eps_reg    <= '0;
      eval_out_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_start) begin
            acc_reg      <= '0;
            eval_out_reg <= '0;
            idx_reg      <= LAST_IDX;
            j_reg        <= '0;
            r_eps_reg    <= i_r_eps;
          end
        end
        RD_WAIT: begin
          coef_reg <= i_q_s;
`ifdef EVALUATE_FIRST_MUL_SKIP_EN
          // Leading term: 0*r ^ c equals c, so load it directly
          if (last_idx) acc_reg <= {24'b0, i_q_s};
`endif
        end
        MUL_WAIT: begin
          if (i_done_mul32) acc_reg <= i_o_mul32 ^ {24'b0, coef_reg};
        end
        NEXT: begin
          if (idx_reg != '0) begin
            idx_reg <= idx_reg - 1'b1;
          end else begin
            eval_out_reg[32*j_reg +: 32] <= acc_reg;
            if (!last_point) begin
              j_reg   <= j_reg + 1'b1;
              acc_reg <= '0;
              idx_reg <= LAST_IDX;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // The multiplier operands come straight from registers, so they stay stable
  // for the whole MUL_WAIT period
  assign o_q_s_addr     = idx_reg;
  assign o_x_mul32      = acc_reg;
  assign o_y_mul32      = r_eps_reg[32*j_reg +: 32];
  assign o_evaluate_out = eval_out_reg;

endmodule

// File: tb/tb_evaluate_poly_gf32.sv
// Self-checking bench for evaluate_poly_gf32.
// Main DUT: N_COEF=4, T=3. Second DUT: N_COEF=1, T=2.
// The reference model is a direct power sum, sum of c_i * r^i, over the
// bench's own GF(2^32) multiplier. Expected results go into a scoreboard
// queue. A monitor compares them whenever o_done is seen.
module tb_evaluate_poly_gf32;
  localparam int T  = 3;
  localparam int NC = 4;
`ifdef EVALUATE_FIRST_MUL_SKIP_EN
  localparam int MPP  = NC - 1;
  localparam int MPP1 = 0;
`else
  localparam int MPP  = NC;
  localparam int MPP1 = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main DUT signals
  logic            start = 1'b0;
  logic [32*T-1:0] r_eps = '0;
  logic [1:0]      q_addr;
  logic            q_rd;
  logic [7:0]      q_s = '0;
  logic            st_mul;
  logic [31:0]     x_mul, y_mul;
  logic [31:0]     o_mul = '0;
  logic            done_mul = 1'b0;
  logic [32*T-1:0] eval_out;
  logic            busy, done;

  // second DUT signals (single coefficient)
  logic            start1 = 1'b0;
  logic [63:0]     r_eps1 = '0;
  logic [0:0]      q_addr1;
  logic            q_rd1;
  logic [7:0]      q_s1 = '0;
  logic            st_mul1;
  logic [31:0]     x_mul1, y_mul1;
  logic [31:0]     o_mul1 = '0;
  logic            done_mul1 = 1'b0;
  logic [63:0]     eval_out1;
  logic            busy1, done1;

  evaluate_poly_gf32 #(.T(T), .N_COEF(NC)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_r_eps(r_eps),
    .o_q_s_addr(q_addr), .o_q_s_rd(q_rd), .i_q_s(q_s),
    .o_start_mul32(st_mul), .o_x_mul32(x_mul), .o_y_mul32(y_mul),
    .i_o_mul32(o_mul), .i_done_mul32(done_mul),
    .o_evaluate_out(eval_out), .o_busy(busy), .o_done(done)
  );

  evaluate_poly_gf32 #(.T(2), .N_COEF(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .i_r_eps(r_eps1),
    .o_q_s_addr(q_addr1), .o_q_s_rd(q_rd1), .i_q_s(q_s1),
    .o_start_mul32(st_mul1), .o_x_mul32(x_mul1), .o_y_mul32(y_mul1),
    .i_o_mul32(o_mul1), .i_done_mul32(done_mul1),
    .o_evaluate_out(eval_out1), .o_busy(busy1), .o_done(done1)
  );

  int n_cmp = 0;
  int n_err = 0;
  int rd_cnt = 0, st_cnt = 0, done_cnt = 0;
  logic [7:0] coef [NC];
  logic [7:0] coef1 = '0;
  logic [32*T-1:0] exp_q [$];
  int mul_left = 0;

  // GF(2^32) multiply, reduced by x^32 + x^22 + x^2 + x + 1
  function automatic logic [31:0] gf_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < 32; i++) if (b[i]) p ^= ({32'b0, a} << i);
    for (int i = 63; i >= 32; i--) if (p[i]) p ^= (64'h1_0040_0007 << (i - 32));
    return p[31:0];
  endfunction

  // Reference: P(r) = XOR over i of c_i * r^i, computed by explicit powers
  function automatic logic [32*T-1:0] eval_model(input logic [32*T-1:0] r);
    logic [32*T-1:0] res;
    logic [31:0] sum, pw, rj;
    res = '0;
    for (int j = 0; j < T; j++) begin
      rj  = r[32*j +: 32];
      sum = '0;
      pw  = 32'd1;
      for (int i = 0; i < NC; i++) begin
        sum ^= gf_mul({24'b0, coef[i]}, pw);
        pw = gf_mul(pw, rj);
      end
      res[32*j +: 32] = sum;
    end
    return res;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // coefficient memory: data valid one cycle after the read strobe, junk otherwise
  always @(posedge clk) begin
    q_s  <= q_rd  ? coef[q_addr] : 8'($urandom);
    q_s1 <= q_rd1 ? coef1        : 8'($urandom);
  end

  // multiplier model: random 1..3 cycle latency, spurious done pulses when idle
  always @(posedge clk) begin
    if (mul_left > 0) begin
      if (mul_left == 1) begin
        done_mul <= 1'b1;
        o_mul    <= gf_mul(x_mul, y_mul);
      end else begin
        done_mul <= 1'b0;
        o_mul    <= $urandom;
      end
      mul_left <= mul_left - 1;
    end else if (st_mul) begin
      mul_left <= $urandom_range(1, 3);
      done_mul <= 1'b0;
      o_mul    <= $urandom;
    end else begin
      done_mul <= ($urandom_range(0, 5) == 0);
      o_mul    <= $urandom;
    end
    done_mul1 <= st_mul1;
    o_mul1    <= gf_mul(x_mul1, y_mul1);
  end

  // pulse counters and strobe exclusivity
  always @(negedge clk) begin
    if (q_rd)   rd_cnt++;
    if (st_mul) st_cnt++;
    if (done)   done_cnt++;
    if (q_rd && st_mul) begin
      n_err++;
      $display("FAIL rd_and_mul_start_overlap: got 1 expected 0");
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got 1 expected 0");
      end else begin
        logic [32*T-1:0] e;
        e = exp_q.pop_front();
        for (int j = 0; j < T; j++) check($sformatf("slot%0d", j), eval_out[32*j +: 32], e[32*j +: 32]);
      end
    end
  end

  task automatic run_job(input logic [32*T-1:0] r, input bit second_start);
    logic [32*T-1:0] e;
    int rd0, st0, d0;
    bit got;
    e = eval_model(r);
    exp_q.push_back(e);
    @(negedge clk);
    rd0 = rd_cnt; st0 = st_cnt; d0 = done_cnt;
    r_eps = r;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    r_eps = {$urandom, $urandom, $urandom};
    check("busy_after_start", 32'(busy), 32'd1);
    if (second_start) begin
      repeat (5) @(negedge clk);
      r_eps = ~r;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    got = 1'b0;
    for (int k = 0; k < 3000 && !got; k++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    check("done_seen", 32'(got), 32'd1);
    if (!got) exp_q.delete();
    check("rd_pulses", 32'(rd_cnt - rd0), 32'(T * NC));
    check("mul_starts", 32'(st_cnt - st0), 32'(T * MPP));
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    for (int j = 0; j < T; j++) check($sformatf("hold_slot%0d", j), eval_out[32*j +: 32], e[32*j +: 32]);
    check("done_count", 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    logic [32*T-1:0] r;
    int n;
    int rd1n, st1n;
    bit got;
    for (int i = 0; i < NC; i++) coef[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd", 32'(q_rd), 32'd0);
    check("rst_addr", 32'(q_addr), 32'd0);
    check("rst_mul_start", 32'(st_mul), 32'd0);
    for (int j = 0; j < T; j++) check("rst_out", eval_out[32*j +: 32], 32'd0);
    rst = 1'b0;

    // all-zero coefficients
    run_job({$urandom, $urandom, $urandom}, 1'b0);
    // r = 1, coefficients 1,2,4,8 -> 0x0F everywhere
    coef[0] = 8'h01; coef[1] = 8'h02; coef[2] = 8'h04; coef[3] = 8'h08;
    run_job({32'd1, 32'd1, 32'd1}, 1'b0);
    check("model_sanity_0f", eval_model({32'd1, 32'd1, 32'd1}) >> 64, 32'h0000000F);
    // r = {0,1,0}, c0 = A5, others 11
    coef[0] = 8'hA5; coef[1] = 8'h11; coef[2] = 8'h11; coef[3] = 8'h11;
    run_job({32'd0, 32'd1, 32'd0}, 1'b0);
    // random points and coefficients, one with an ignored second start
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < NC; i++) coef[i] = 8'($urandom);
      run_job({$urandom, $urandom, $urandom}, t == 2);
    end

    // reset in MUL_WAIT of point 1
    for (int i = 0; i < NC; i++) coef[i] = 8'($urandom);
    @(negedge clk);
    r_eps = {$urandom, $urandom, $urandom};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    for (int k = 0; k < 500 && n < MPP + 1; k++) begin
      if (st_mul) n++;
      if (n < MPP + 1) @(negedge clk);
    end
    check("reached_point1_mul", 32'(n), 32'(MPP + 1));
    @(negedge clk);
    rst = 1'b1;
    n = done_cnt;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_rd", 32'(q_rd), 32'd0);
    for (int j = 0; j < T; j++) check("abort_out", eval_out[32*j +: 32], 32'd0);
    repeat (20) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - n), 32'd0);

    // reset takes priority over a simultaneous start
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    n = rd_cnt;
    check("rst_prio_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    check("rst_prio_no_rd", 32'(rd_cnt - n), 32'd0);

    // recovery after abort
    for (int i = 0; i < NC; i++) coef[i] = 8'($urandom);
    run_job({$urandom, $urandom, $urandom}, 1'b0);

    // single coefficient: one read per point, result = lift(c0)
    coef1 = 8'($urandom_range(1, 255));
    @(negedge clk);
    r_eps1 = {$urandom, $urandom};
    start1 = 1'b1;
    rd1n = 0; st1n = 0; got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (q_rd1) rd1n++;
      if (st_mul1) st1n++;
      if (done1) got = 1'b1;
    end
    check("n1_done_seen", 32'(got), 32'd1);
    check("n1_rd_pulses", 32'(rd1n), 32'd2);
    check("n1_mul_starts", 32'(st1n), 32'(2 * MPP1));
    check("n1_slot0", eval_out1[31:0], {24'b0, coef1});
    check("n1_slot1", eval_out1[63:32], {24'b0, coef1});

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  // global watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/evaluate_poly_gf32.md
EVALUATE_POLY_GF32 -- requirements
Module: evaluate_poly_gf32

Interface
REQ-001 SHALL have parameter T, default 3: number of GF(2^32) evaluation points.
REQ-002 SHALL have parameter N_COEF, default 230: number of GF256 polynomial coefficients.
REQ-003 SHALL have port i_clk, input, 1: clock.
REQ-004 SHALL have port i_rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port i_start, input, 1: start pulse.
REQ-006 SHALL have port i_r_eps, input, 32*T: evaluation points; point j in bits [32j+31:32j].
REQ-007 SHALL have port o_q_s_addr, output, CLOG2(N_COEF): coefficient read address.
REQ-008 SHALL have port o_q_s_rd, output, 1: coefficient read strobe.
REQ-009 SHALL have port i_q_s, input, 8: coefficient data, valid one cycle after o_q_s_rd.
REQ-010 SHALL have ports o_start_mul32 (output, 1), o_x_mul32 (output, 32), o_y_mul32 (output, 32), i_o_mul32 (input, 32), i_done_mul32 (input, 1): external GF(2^32) multiplier handshake.
REQ-011 SHALL have port o_evaluate_out, output, 32*T: results; slot j in bits [32j+31:32j].
REQ-012 SHALL have port o_busy, output, 1: high from the cycle after accepted start until o_done.
REQ-013 SHALL have port o_done, output, 1: one-cycle completion pulse.

Function
REQ-014 SHALL compute, per point j, P(r_j) = XOR over i of lift(c_i)*r_j^i with Horner's rule, i from N_COEF-1 down to 0; lift(c) = {24'b0, c}.
REQ-015 SHALL latch i_r_eps into an internal register on the accepted i_start; later i_r_eps changes have no effect.
REQ-016 SHALL process points in order j = 0..T-1.
REQ-017 SHALL use states IDLE, RD, RD_WAIT, MUL_START, MUL_WAIT, NEXT, DONE.
REQ-018 IDLE: accept i_start, clear accumulator, zero o_evaluate_out, set address N_COEF-1, point index 0, go to RD.
REQ-019 RD: assert o_q_s_rd for exactly one cycle with o_q_s_addr = current index; go to RD_WAIT.
REQ-020 RD_WAIT: latch i_q_s as coefficient; go to MUL_START.
REQ-021 MUL_START: pulse o_start_mul32 one cycle with o_x_mul32 = accumulator, o_y_mul32 = latched r_j; go to MUL_WAIT.
REQ-022 MUL_WAIT: hold o_x/o_y stable; on i_done_mul32, accumulator <= i_o_mul32 XOR lift(coefficient); go to NEXT.
REQ-023 NEXT: if index > 0, decrement and go to RD; else write accumulator to slot j. If j < T-1, increment j, clear accumulator, reset index to N_COEF-1, and go to RD; otherwise go to DONE.
REQ-024 DONE: pulse o_done one cycle, drop o_busy, return to IDLE.
REQ-025 o_evaluate_out SHALL hold its value from o_done until the next accepted i_start.
REQ-026 i_start while not IDLE SHALL be ignored.
REQ-027 i_done_mul32 outside MUL_WAIT SHALL be ignored.
REQ-028 o_q_s_rd and o_start_mul32 SHALL never be high simultaneously.
REQ-029 With N_COEF = 1, SHALL perform exactly one read per point and produce lift(c_0).

Reset
REQ-030 On i_rst, SHALL go to IDLE next cycle from any state, abandoning any operation without an o_done pulse.
REQ-031 Reset values: o_done 0, o_busy 0, o_q_s_rd 0, o_q_s_addr 0, o_start_mul32 0, o_evaluate_out 0, accumulator 0.
REQ-032 i_rst SHALL take priority over a simultaneous i_start.

Configuration
REQ-033 With macro EVALUATE_FIRST_MUL_SKIP_EN defined, for index N_COEF-1 RD_WAIT SHALL load accumulator = lift(c_{N_COEF-1}) and go directly to NEXT, giving N_COEF-1 multiplications per point.
REQ-034 With EVALUATE_FIRST_MUL_SKIP_EN undefined, every coefficient SHALL take the full multiply path, giving N_COEF multiplications per point; results SHALL be identical in both builds.

Verification
REQ-035 N_COEF=4, T=3, all coefficients 0x00, any r -> o_evaluate_out = 0, exactly one o_done pulse.
REQ-036 N_COEF=4, r_j = 0x00000001 for all j, coefficients {0x01,0x02,0x04,0x08} -> every slot = 0x0000000F.
REQ-037 r = {0x0, 0x1, 0x0}, c_0 = 0xA5, others 0x11 -> slot0 = 0x000000A5, slot1 = 0x000000A5^0x11^0x11^0x11 = 0x000000B4, slot2 = 0x000000A5.
REQ-038 N_COEF=4, T=3, multiplier model done 2 cycles after start -> 12 o_start_mul32 pulses without the macro, 9 with it; 12 o_q_s_rd pulses in both builds.
REQ-039 i_rst asserted in MUL_WAIT of point 1 -> IDLE next cycle, no o_done, o_busy 0, o_evaluate_out = 0.
REQ-040 Second i_start during busy with a different i_r_eps -> ignored, results match the first r set, single o_done.
